lock_code_sender: RTL and testbench

//   Transmit side of the two-button combination-lock interface. On a start request it

---
 rtl/lock_code_sender.sv | 137 +++++++++++++
 tb/tb_lock_code_sender.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_code_sender.sv
// Purpose: plays a fixed button press code into the lock, waits for unlock, retries on timeout.
// Latency: first press the cycle after start is sampled; done/fail one cycle after the deciding WAIT cycle.
// Backpressure: none; start is only looked at while idle, there is no request queue.
module lock_code_sender #(
    parameter int                  CODE_LEN   = 6,
    parameter logic [CODE_LEN-1:0] CODE       = 6'b001011,
    parameter int                  GAP_CYCLES = 2,
    parameter int                  TIMEOUT    = 8,
    parameter int                  RETRIES    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic unlock,
    output logic button_0,
    output logic button_1,
    output logic busy,
    output logic done,
    output logic fail
);

    localparam int SW = $clog2(CODE_LEN + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int AW = $clog2(RETRIES + 2);

    // Code zero-extended to a power of two so a step-wide index always fits exactly.
    localparam logic [(1 << SW)-1:0] CODE_PAD  = {{((1 << SW) - CODE_LEN){1'b0}}, CODE};
    localparam logic [SW-1:0]        STEP_LAST = SW'(CODE_LEN - 1);
    localparam logic [GW-1:0]        GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [WW-1:0]        WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [AW-1:0]        ATT_MAX   = AW'(RETRIES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_GAP,
        S_WAIT
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_step;
    logic [GW-1:0]   r_gap;
    logic [WW-1:0]   r_wait;
    logic [AW-1:0]   r_attempt;
    logic [SW-1:0]   w_step_nxt;
    logic            w_bit_first;
    logic            w_bit_nxt;

    assign w_step_nxt  = r_step + SW'(1);
    assign w_bit_first = CODE_PAD[0];
    assign w_bit_nxt   = CODE_PAD[w_step_nxt];

    // Sequencer: registered outputs are set for the state being entered, so a button
    // is high exactly in its PRESS cycle. The final press has no trailing gap: WAIT
    // starts the cycle right after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_step    <= '0;
            r_gap     <= '0;
            r_wait    <= '0;
            r_attempt <= '0;
            button_0  <= 1'b0;
            button_1  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            button_0 <= 1'b0;
            button_1 <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_PRESS;
                        r_step    <= '0;
                        r_attempt <= '0;
                        busy      <= 1'b1;
                        button_1  <= w_bit_first;
                        button_0  <= ~w_bit_first;
                    end
                end
                S_PRESS: begin
                    if (r_step == STEP_LAST) begin
                        r_state <= S_WAIT;
                        r_wait  <= '0;
                    end else if (GAP_CYCLES > 0) begin
                        r_state <= S_GAP;
                        r_gap   <= '0;
                    end else begin
                        r_step   <= w_step_nxt;
                        button_1 <= w_bit_nxt;
                        button_0 <= ~w_bit_nxt;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state  <= S_PRESS;
                        r_step   <= w_step_nxt;
                        button_1 <= w_bit_nxt;
                        button_0 <= ~w_bit_nxt;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                S_WAIT: begin
                    if (unlock) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (r_wait == WAIT_LAST) begin
                        if (r_attempt < ATT_MAX) begin
                            r_state   <= S_PRESS;
                            r_step    <= '0;
                            r_attempt <= r_attempt + AW'(1);
                            button_1  <= w_bit_first;
                            button_0  <= ~w_bit_first;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            fail    <= 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_code_sender.sv
// Purpose: self-checking bench for lock_code_sender, default build plus a GAP=0/TIMEOUT=1 build.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is per-cycle start/unlock tables.
module tb_lock_code_sender;

    localparam int         MAXC    = 240;
    localparam int         CLEN    = 6;
    localparam logic [5:0] TB_CODE = 6'b001011;

    // Output vector encoding: {button_0, button_1, busy, done, fail}
    localparam logic [4:0] V_IDLE = 5'b00000;
    localparam logic [4:0] V_P0   = 5'b10100;
    localparam logic [4:0] V_P1   = 5'b01100;
    localparam logic [4:0] V_BUSY = 5'b00100;
    localparam logic [4:0] V_DONE = 5'b00010;
    localparam logic [4:0] V_FAIL = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0, unlock_a = 1'b0;
    logic start_b = 1'b0, unlock_b = 1'b0;
    logic b0_a, b1_a, busy_a, done_a, fail_a;
    logic b0_b, b1_b, busy_b, done_b, fail_b;

    bit         s   [MAXC];
    bit         u   [MAXC];
    logic [4:0] ev  [MAXC];
    logic [4:0] obsv[MAXC];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lock_code_sender dut_a (
        .clk(clk), .rst(rst), .start(start_a), .unlock(unlock_a),
        .button_0(b0_a), .button_1(b1_a), .busy(busy_a), .done(done_a), .fail(fail_a)
    );

    lock_code_sender #(.GAP_CYCLES(0), .TIMEOUT(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .unlock(unlock_b),
        .button_0(b0_b), .button_1(b1_b), .busy(busy_b), .done(done_b), .fail(fail_b)
    );

    function automatic logic [4:0] outs(input int sel);
        if (sel == 0) return {b0_a, b1_a, busy_a, done_a, fail_a};
        return {b0_b, b1_b, busy_b, done_b, fail_b};
    endfunction

    function automatic void setv(input int c, input logic [4:0] v);
        if (c < MAXC) ev[c] = v;
    endfunction

    // Reference: walk the start table; each accepted request expands into the press
    // list (gaps between presses only), a WAIT window scanning the unlock table, and
    // a closing done/fail cycle which is idle and may accept the next start.
    task automatic model(input int gap, input int tmo, input int ret, input int n);
        int t, c;
        bit ok;
        for (int i = 0; i < MAXC; i++) ev[i] = V_IDLE;
        t = 0;
        while (t < n) begin
            if (!s[t]) begin
                t++;
            end else begin
                c  = t + 1;
                ok = 1'b0;
                for (int a = 0; a <= ret && !ok; a++) begin
                    for (int p = 0; p < CLEN; p++) begin
                        setv(c, TB_CODE[p] ? V_P1 : V_P0);
                        c++;
                        if (p < CLEN - 1)
                            for (int g = 0; g < gap; g++) begin
                                setv(c, V_BUSY);
                                c++;
                            end
                    end
                    for (int w = 0; w < tmo && !ok; w++) begin
                        setv(c, V_BUSY);
                        if (c < MAXC && u[c]) ok = 1'b1;
                        c++;
                    end
                end
                setv(c, ok ? V_DONE : V_FAIL);
                t = c;
            end
        end
    endtask

    task automatic clear_tables();
        for (int i = 0; i < MAXC; i++) begin
            s[i] = 1'b0;
            u[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        start_a = 0; unlock_a = 0; start_b = 0; unlock_b = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drives table entries to one DUT for n cycles and records its outputs per cycle.
    task automatic run(input int sel, input int n);
        obsv[0] = outs(sel);
        for (int c = 0; c < n; c++) begin
            if (sel == 0) begin start_a = s[c]; unlock_a = u[c]; end
            else          begin start_b = s[c]; unlock_b = u[c]; end
            @(posedge clk); #1;
            obsv[c + 1] = outs(sel);
        end
        start_a = 0; unlock_a = 0; start_b = 0; unlock_b = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++;
        if (outs(0) !== V_IDLE) begin
            errors++;
            $display("FAIL reset_a got=%b want=%b", outs(0), V_IDLE);
        end
        checks++;
        if (outs(1) !== V_IDLE) begin
            errors++;
            $display("FAIL reset_b got=%b want=%b", outs(1), V_IDLE);
        end
        do_reset();
    endtask

    task automatic test_unlock_first_try();
        do_reset(); clear_tables();
        s[0] = 1; u[17] = 1;
        model(2, 8, 1, 30); run(0, 30);
        for (int c = 0; c <= 30; c++) begin
            checks++;
            if (obsv[c] !== ev[c]) begin
                errors++;
                $display("FAIL first_try cyc=%0d got=%b want=%b", c, obsv[c], ev[c]);
            end
        end
        checks++;
        if (obsv[1] !== V_P1 || obsv[7] !== V_P0 || obsv[16] !== V_P0) begin
            errors++;
            $display("FAIL first_try_presses got=%b/%b/%b want=%b/%b/%b",
                     obsv[1], obsv[7], obsv[16], V_P1, V_P0, V_P0);
        end
        checks++;
        if (obsv[18] !== V_DONE) begin
            errors++;
            $display("FAIL first_try_done got=%b want=%b", obsv[18], V_DONE);
        end
    endtask

    task automatic test_timeout_fail(input bit noise);
        do_reset(); clear_tables();
        s[0] = 1;
        if (noise) begin u[5] = 1; u[6] = 1; end
        model(2, 8, 1, 60); run(0, 60);
        for (int c = 0; c <= 60; c++) begin
            checks++;
            if (obsv[c] !== ev[c]) begin
                errors++;
                $display("FAIL timeout noise=%0d cyc=%0d got=%b want=%b", noise, c, obsv[c], ev[c]);
            end
        end
        checks++;
        if (obsv[24] !== V_BUSY || obsv[25] !== V_P1 || obsv[48] !== V_BUSY || obsv[49] !== V_FAIL) begin
            errors++;
            $display("FAIL timeout_edges noise=%0d got=%b/%b/%b/%b want=%b/%b/%b/%b", noise,
                     obsv[24], obsv[25], obsv[48], obsv[49], V_BUSY, V_P1, V_BUSY, V_FAIL);
        end
    endtask

    task automatic test_start_held();
        do_reset(); clear_tables();
        for (int i = 0; i <= 30; i++) s[i] = 1;
        u[17] = 1; u[35] = 1;
        model(2, 8, 1, 45); run(0, 45);
        for (int c = 0; c <= 45; c++) begin
            checks++;
            if (obsv[c] !== ev[c]) begin
                errors++;
                $display("FAIL start_held cyc=%0d got=%b want=%b", c, obsv[c], ev[c]);
            end
        end
        checks++;
        if (obsv[18] !== V_DONE || obsv[19] !== V_P1 || obsv[36] !== V_DONE) begin
            errors++;
            $display("FAIL start_held_retrigger got=%b/%b/%b want=%b/%b/%b",
                     obsv[18], obsv[19], obsv[36], V_DONE, V_P1, V_DONE);
        end
    endtask

    task automatic test_reset_midgap();
        do_reset(); clear_tables();
        s[0] = 1;
        model(2, 8, 1, 8); run(0, 8);
        for (int c = 0; c <= 8; c++) begin
            checks++;
            if (obsv[c] !== ev[c]) begin
                errors++;
                $display("FAIL midgap_pre cyc=%0d got=%b want=%b", c, obsv[c], ev[c]);
            end
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (outs(0) !== V_IDLE) begin
            errors++;
            $display("FAIL midgap_async_clear got=%b want=%b", outs(0), V_IDLE);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        clear_tables();
        for (int i = 0; i < 30; i++) s[i] = (i == 10);
        u[27] = 1;
        model(2, 8, 1, 35); run(0, 35);
        for (int c = 0; c <= 35; c++) begin
            checks++;
            if (obsv[c] !== ev[c]) begin
                errors++;
                $display("FAIL midgap_replay cyc=%0d got=%b want=%b", c, obsv[c], ev[c]);
            end
        end
        checks++;
        if (obsv[11] !== V_P1 || obsv[28] !== V_DONE) begin
            errors++;
            $display("FAIL midgap_replay_step0 got=%b/%b want=%b/%b", obsv[11], obsv[28], V_P1, V_DONE);
        end
    endtask

    task automatic test_no_gap(input int unlock_at);
        do_reset(); clear_tables();
        s[0] = 1; u[unlock_at] = 1;
        model(0, 1, 1, 20); run(1, 20);
        for (int c = 0; c <= 20; c++) begin
            checks++;
            if (obsv[c] !== ev[c]) begin
                errors++;
                $display("FAIL no_gap u=%0d cyc=%0d got=%b want=%b", unlock_at, c, obsv[c], ev[c]);
            end
        end
        checks++;
        if (obsv[8] !== ((unlock_at == 7) ? V_DONE : V_P1)) begin
            errors++;
            $display("FAIL no_gap_c8 u=%0d got=%b want=%b", unlock_at, obsv[8],
                     (unlock_at == 7) ? V_DONE : V_P1);
        end
    endtask

    task automatic test_random(input int sel);
        for (int k = 0; k < 4; k++) begin
            do_reset(); clear_tables();
            for (int i = 0; i < 150; i++) begin
                s[i] = (i < 90) && ($urandom_range(0, 9) == 0);
                u[i] = ($urandom_range(0, 5) == 0);
            end
            if (sel == 0) model(2, 8, 1, 150);
            else          model(0, 1, 1, 150);
            run(sel, 150);
            for (int c = 0; c <= 150; c++) begin
                checks++;
                if (obsv[c] !== ev[c]) begin
                    errors++;
                    $display("FAIL random dut=%0d rep=%0d cyc=%0d got=%b want=%b", sel, k, c, obsv[c], ev[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unlock_first_try();
        test_timeout_fail(1'b0);
        test_start_held();
        test_timeout_fail(1'b1);
        test_reset_midgap();
        test_no_gap(7);
        test_no_gap(8);
        test_random(0);
        test_random(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
